// File: rtl/wash_pkg.sv
// Shared state, fault and program-timing types for the wash sequencer.
// All durations are counted in ticks of the shared time base.
package wash_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_DOOR     = 4'd1,
    S_FILL     = 4'd2,
    S_DET      = 4'd3,
    S_WASH     = 4'd4,
    S_DRAIN    = 4'd5,
    S_SPIN     = 4'd6,
    S_COMPLETE = 4'd7,
    S_ABORT    = 4'd8,
    S_FAULT    = 4'd9
  } seq_state_t;

  typedef enum logic [1:0] {
    FC_NONE  = 2'd0,
    FC_FILL  = 2'd1,
    FC_DRAIN = 2'd2,
    FC_DOOR  = 2'd3
  } fault_code_t;

  localparam int DUR_W = 8;
  typedef logic [DUR_W-1:0] dur_t;

  typedef struct packed {
    dur_t det;
    dur_t wash;
    dur_t spin;
  } prog_dur_t;

  localparam dur_t QUICK_DET  = 8'd4;
  localparam dur_t QUICK_WASH = 8'd60;
  localparam dur_t QUICK_SPIN = 8'd30;
  localparam dur_t NORM_DET   = 8'd4;
  localparam dur_t NORM_WASH  = 8'd120;
  localparam dur_t NORM_SPIN  = 8'd60;
  localparam dur_t HEAVY_DET  = 8'd6;
  localparam dur_t HEAVY_WASH = 8'd240;
  localparam dur_t HEAVY_SPIN = 8'd90;
  localparam dur_t RINSE_DET  = 8'd0;
  localparam dur_t RINSE_WASH = 8'd30;
  localparam dur_t RINSE_SPIN = 8'd30;

  function automatic prog_dur_t prog_dur(
    input logic [1:0] prog
  );
    prog_dur_t r;
    unique case (prog)
      2'd0: r = '{QUICK_DET, QUICK_WASH, QUICK_SPIN};
      2'd1: r = '{NORM_DET, NORM_WASH, NORM_SPIN};
      2'd2: r = '{HEAVY_DET, HEAVY_WASH, HEAVY_SPIN};
      default: r = '{RINSE_DET, RINSE_WASH, RINSE_SPIN};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase tick counter with an equality compare against the
// duration of whichever phase is currently running.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic             tick,
  input  logic [CNT_W-1:0] dur,
  output logic [CNT_W-1:0] cnt,
  output logic             hit
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && tick) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign hit = (cnt == dur);

endmodule

// File: rtl/wash_program_sequencer.sv
// Washer program controller: sequences door, fill, detergent, wash,
// drain and spin, and owns door lock, pause, abort and faults.
module wash_program_sequencer
  import wash_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int FILL_TO  = 200,
  parameter int DRAIN_TO = 100
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       start,
  input  logic [1:0] prog,
  input  logic       pause,
  input  logic       abort,
  input  logic       door_closed,
  input  logic       level_full,
  input  logic       level_empty,
  output logic [5:0] step_done,
  output logic       valve_on,
  output logic       detergent_on,
  output logic       motor_on,
  output logic       motor_fast,
  output logic       pump_on,
  output logic       door_lock,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_code
);

  seq_state_t  state, state_d;
  fault_code_t fc, fc_d;
  logic [1:0]  prog_q;
  prog_dur_t   durs;

  logic [CNT_W-1:0] dur;
  logic             hit;

  logic       phase_end, door_open, timeout;
  logic [5:0] step, sd_d;
  logic       valve_d, det_d, motor_d, fast_d;
  logic       pump_d, lock_d;

  assign durs = prog_dur(prog_q);

  always_comb begin
    dur = '0;
    unique case (1'b1)
      state == S_FILL:  dur = CNT_W'(FILL_TO);
      state == S_DET:   dur = CNT_W'(durs.det);
      state == S_WASH:  dur = CNT_W'(durs.wash);
      state == S_DRAIN: dur = CNT_W'(DRAIN_TO);
      state == S_SPIN:  dur = CNT_W'(durs.spin);
      default: ;
    endcase
  end

  // Counter restarts on every state change, so each phase sees cnt=0.
  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (state_d != state),
    .enable  (!pause),
    .tick    (tick),
    .dur     (dur),
    .cnt     (),
    .hit     (hit)
  );

  always_comb begin
    phase_end = 1'b0;
    step      = '0;
    unique case (state)
      S_DOOR: begin
        phase_end = door_closed;
        step      = 6'b000001;
      end
      S_FILL: begin
        phase_end = level_full;
        step      = 6'b000010;
      end
      S_DET: begin
        phase_end = hit;
        step      = 6'b000100;
      end
      S_WASH: begin
        phase_end = hit;
        step      = 6'b001000;
      end
      S_DRAIN: begin
        phase_end = level_empty;
        step      = 6'b010000;
      end
      S_SPIN: begin
        phase_end = hit;
        step      = 6'b100000;
      end
      default: ;
    endcase
  end

  assign door_open = !door_closed
                  && (state >= S_FILL)
                  && (state <= S_SPIN);
  assign timeout   = hit
                  && (state == S_FILL
                   || state == S_DRAIN);

  always_comb begin
    state_d = state;
    fc_d    = fc;
    sd_d    = '0;
    unique case (state)
      S_IDLE: begin
        if (start) state_d = S_DOOR;
      end
      S_COMPLETE: state_d = S_IDLE;
      S_ABORT: begin
        if (level_empty) state_d = S_IDLE;
      end
      S_FAULT: begin
        if (abort && level_empty) begin
          state_d = S_IDLE;
          fc_d    = FC_NONE;
        end
      end
      default: begin
        if (abort) begin
          state_d = S_ABORT;
        end else if (door_open) begin
          state_d = S_FAULT;
          fc_d    = FC_DOOR;
        end else if (timeout) begin
          state_d = S_FAULT;
          fc_d    = (state == S_FILL) ? FC_FILL
                                      : FC_DRAIN;
        end else if (phase_end) begin
          // Active phases are encoded in run order.
          state_d = seq_state_t'(state + 4'd1);
          sd_d    = step;
        end
      end
    endcase
  end

  always_comb begin
    valve_d = (state_d == S_FILL) && !pause;
    det_d   = (state_d == S_DET) && !pause;
    motor_d = (state_d == S_WASH
            || state_d == S_SPIN) && !pause;
    fast_d  = (state_d == S_SPIN) && !pause;
    pump_d  = ((state_d == S_DRAIN
             || state_d == S_SPIN) && !pause)
           || state_d == S_ABORT
           || (state_d == S_FAULT && !level_empty);
    lock_d  = (state_d >= S_FILL
            && state_d <= S_SPIN)
           || state_d == S_ABORT
           || (state_d == S_FAULT && !level_empty);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      fc           <= FC_NONE;
      prog_q       <= '0;
      step_done    <= '0;
      valve_on     <= 1'b0;
      detergent_on <= 1'b0;
      motor_on     <= 1'b0;
      motor_fast   <= 1'b0;
      pump_on      <= 1'b0;
      door_lock    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
    end else begin
      state        <= state_d;
      fc           <= fc_d;
      if (state == S_IDLE && start) prog_q <= prog;
      step_done    <= sd_d;
      valve_on     <= valve_d;
      detergent_on <= det_d;
      motor_on     <= motor_d;
      motor_fast   <= fast_d;
      pump_on      <= pump_d;
      door_lock    <= lock_d;
      busy         <= (state_d != S_IDLE);
      done         <= (state_d == S_COMPLETE);
      fault        <= (state_d == S_FAULT);
    end
  end

  assign fault_code = fc;

endmodule

// File: tb/tb_wash_program_sequencer.sv
// Self-checking bench: expected pulse order is queued when a program
// is started and popped by a monitor as step_done/done pulses appear.
module tb_wash_program_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [1:0] prog = 2'd0;
  logic       pause = 1'b0;
  logic       abort = 1'b0;
  logic       door_closed = 1'b1;
  logic       level_full = 1'b0;
  logic       level_empty = 1'b1;
  logic [5:0] step_done;
  logic       valve_on, detergent_on;
  logic       motor_on, motor_fast;
  logic       pump_on, door_lock;
  logic       busy, done, fault;
  logic [1:0] fault_code;

  int total = 0;
  int bad = 0;
  int exp_q[$];
  int tcount = 0;
  bit last_tick = 1'b0;
  bit tdiv = 1'b0;
  int ev_incl[7];
  int ev_before[7];
  bit ev_seen[7];
  int det_cycles = 0;

  wash_program_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .tick         (tick),
    .start        (start),
    .prog         (prog),
    .pause        (pause),
    .abort        (abort),
    .door_closed  (door_closed),
    .level_full   (level_full),
    .level_empty  (level_empty),
    .step_done    (step_done),
    .valve_on     (valve_on),
    .detergent_on (detergent_on),
    .motor_on     (motor_on),
    .motor_fast   (motor_fast),
    .pump_on      (pump_on),
    .door_lock    (door_lock),
    .busy         (busy),
    .done         (done),
    .fault        (fault),
    .fault_code   (fault_code)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Tick every other cycle, changed on the negedge.
  initial begin
    forever begin
      @(negedge clk);
      tdiv = !tdiv;
      tick = tdiv;
    end
  end

  // Bench view of counted ticks: those sampled with pause low.
  always @(posedge clk) begin
    last_tick = tick && !pause;
    if (last_tick) tcount++;
  end

  always @(negedge clk) begin : mon
    logic [6:0] evs;
    evs = {done, step_done};
    if (detergent_on) det_cycles++;
    for (int b = 0; b < 7; b++) begin
      if (evs[b]) begin
        ev_seen[b]   = 1'b1;
        ev_incl[b]   = tcount;
        ev_before[b] = tcount - int'(last_tick);
        if (exp_q.size() == 0)
          chk("sb_unexpected", b, 99);
        else
          chk("sb_order", b, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_ev();
    for (int b = 0; b < 7; b++) ev_seen[b] = 1'b0;
    det_cycles = 0;
    exp_q.delete();
  endtask

  task automatic push_seq(input int last);
    for (int b = 0; b <= last; b++) exp_q.push_back(b);
  endtask

  task automatic wait_ev(input int b, input int budget);
    int n;
    n = 0;
    while (!ev_seen[b] && n < budget) begin
      step();
      n++;
    end
    if (!ev_seen[b]) chk($sformatf("wait_ev%0d", b), 0, 1);
  endtask

  task automatic wait_ticks(input int n);
    int t0;
    int k;
    t0 = tcount;
    k = 0;
    while (tcount - t0 < n && k < 4 * n + 20) begin
      step();
      k++;
    end
  endtask

  task automatic start_prog(input logic [1:0] p);
    prog  = p;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start", busy, 1);
  endtask

  task automatic run_to_det(input logic [1:0] p);
    start_prog(p);
    wait_ev(0, 20);
    wait_ticks(3);
    level_full = 1'b1;
    wait_ev(1, 20);
    level_full = 1'b0;
  endtask

  task automatic run_normal(
    input logic [1:0] p,
    input int         det,
    input int         wash,
    input int         spin,
    input bit         do_pause
  );
    int k;
    clear_ev();
    level_empty = 1'b0;
    push_seq(6);
    run_to_det(p);
    if (do_pause) begin
      wait_ev(2, 60);
      k = 0;
      while (tcount - ev_incl[2] < 20 && k < 200) begin
        step();
        k++;
      end
      pause = 1'b1;
      step();
      step();
      chk("pause_motor", motor_on, 0);
      chk("pause_cnt", dut.u_timer.cnt, 20);
      repeat (20) step();
      chk("pause_cnt_hold", dut.u_timer.cnt, 20);
      chk("pause_lock", door_lock, 1);
      pause = 1'b0;
      step();
      step();
      chk("resume_motor", motor_on, 1);
    end
    wait_ev(3, 4 * wash + 100);
    wait_ticks(2);
    level_empty = 1'b1;
    wait_ev(4, 20);
    wait_ev(6, 4 * spin + 100);
    step();
    chk("busy_end", busy, 0);
    chk("done_once", done, 0);
    chk("det_len", ev_before[2] - ev_incl[1], det);
    chk("wash_len", ev_before[3] - ev_incl[2], wash);
    chk("spin_len", ev_before[5] - ev_incl[4], spin);
    if (p == 2'd3) chk("det_cycles", det_cycles, 1);
    chk("sb_left", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: no finish by time limit");
    $fatal(1);
  end

  initial begin
    int n;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_step", step_done, 0);
    chk("rst_lock", door_lock, 0);
    chk("rst_fault", {fault, fault_code}, 0);
    chk("rst_act", {valve_on, detergent_on, motor_on,
                    motor_fast, pump_on, done}, 0);
    reset_n = 1'b1;
    step();

    run_normal(2'd0, 4, 60, 30, 1'b0);
    run_normal(2'd3, 0, 30, 30, 1'b0);
    run_normal(2'd0, 4, 60, 30, 1'b1);

    // fill timeout
    clear_ev();
    level_empty = 1'b0;
    push_seq(0);
    start_prog(2'd0);
    wait_ev(0, 20);
    n = 0;
    while (!fault && n < 1000) begin
      step();
      n++;
    end
    chk("fto_fault", fault, 1);
    chk("fto_code", fault_code, 1);
    chk("fto_valve", valve_on, 0);
    chk("fto_pump", pump_on, 1);
    chk("fto_lock", door_lock, 1);
    chk("fto_len", tcount - int'(last_tick) - ev_incl[0], 200);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("fto_hold", fault, 1);
    level_empty = 1'b1;
    step();
    chk("fto_pump_off", pump_on, 0);
    chk("fto_unlock", door_lock, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("fto_clr", fault, 0);
    chk("fto_code_clr", fault_code, 0);
    chk("fto_idle", busy, 0);
    chk("fto_sb", exp_q.size(), 0);

    // abort mid-wash
    clear_ev();
    level_empty = 1'b0;
    push_seq(2);
    run_to_det(2'd1);
    wait_ev(2, 60);
    wait_ticks(10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_pump", pump_on, 1);
    chk("ab_lock", door_lock, 1);
    chk("ab_motor", motor_on, 0);
    repeat (6) step();
    chk("ab_busy", busy, 1);
    level_empty = 1'b1;
    step();
    chk("ab_idle", busy, 0);
    chk("ab_pump_off", pump_on, 0);
    chk("ab_unlock", door_lock, 0);
    repeat (4) step();
    chk("ab_sb", exp_q.size(), 0);

    // door opened in spin
    clear_ev();
    level_empty = 1'b0;
    push_seq(4);
    run_to_det(2'd0);
    wait_ev(3, 400);
    wait_ticks(2);
    level_empty = 1'b1;
    wait_ev(4, 20);
    wait_ticks(5);
    chk("spin_fast", motor_fast, 1);
    door_closed = 1'b0;
    step();
    chk("door_fault", fault, 1);
    chk("door_code", fault_code, 3);
    chk("door_motor", motor_on, 0);
    chk("door_pump", pump_on, 0);
    door_closed = 1'b1;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("door_clr", {fault, fault_code}, 0);
    chk("door_sb", exp_q.size(), 0);

    // reset mid-fill
    clear_ev();
    level_empty = 1'b0;
    push_seq(0);
    start_prog(2'd1);
    wait_ev(0, 20);
    wait_ticks(2);
    chk("mf_valve", valve_on, 1);
    chk("mf_lock", door_lock, 1);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mf_rst_valve", valve_on, 0);
    chk("mf_rst_lock", door_lock, 0);
    chk("mf_rst_busy", busy, 0);
    step();
    reset_n = 1'b1;
    level_empty = 1'b1;
    step();
    step();
    chk("mf_idle", busy, 0);
    chk("mf_sb", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
